// File: rtl/cpu7_muldiv_pkg.sv
// ============================================================================
// cpu7_muldiv_pkg : shared types and constants for the cpu7 mul/div arbiter
// Revision: 1.0
// ============================================================================
`default_nettype none

package cpu7_muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MUL = 2'd0,
        OP_DIV = 2'd1,
        OP_REM = 2'd2,
        OP_RSV = 2'd3
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT    = 2'd2,
        RESPOND = 2'd3
    } arb_state_t;

    // Quotient returned on divide-by-zero; sliced down to the datapath width.
    localparam logic [63:0] C_DBZ_QUOT = '1;

endpackage

`default_nettype wire

// File: rtl/cpu7_rr_picker.sv
// ============================================================================
// cpu7_rr_picker : first set request at or above ptr, wrapping to index 0
// Revision: 1.0
// ============================================================================
`default_nettype none

module cpu7_rr_picker #(
    parameter  int CORES = 2,
    localparam int IDX_W = (CORES > 1) ? $clog2(CORES) : 1
) (
    input  logic [CORES-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_any
);

    always_comb begin
        int               w_idx;
        logic [IDX_W-1:0] w_sel;
        grant_idx = '0;
        grant_any = 1'b0;
        for (int i = 0; i < CORES; i++) begin
            w_idx = int'(ptr) + i;
            if (w_idx >= CORES) w_idx = w_idx - CORES;
            w_sel = IDX_W'(w_idx);
            if (!grant_any && req[w_sel]) begin
                grant_any = 1'b1;
                grant_idx = w_sel;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/cpu7_muldiv_arbiter.sv
// ============================================================================
// cpu7_muldiv_arbiter : round-robin sharing of one mul/div unit pair
// Revision: 1.0
// ============================================================================
`default_nettype none

module cpu7_muldiv_arbiter
    import cpu7_muldiv_pkg::*;
#(
    parameter  int CORES      = 2,
    parameter  int DATA_WIDTH = 28,
    localparam int IDX_W      = (CORES > 1) ? $clog2(CORES) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [CORES-1:0]            req_valid,
    input  logic [CORES*2-1:0]          req_op,
    input  logic [CORES*DATA_WIDTH-1:0] req_a,
    input  logic [CORES*DATA_WIDTH-1:0] req_b,
    output logic [CORES-1:0]            req_ready,
    output logic [CORES-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]       rsp_data,
    output logic                        rsp_dbz,
    output logic                        mul_start,
    output logic                        div_start,
    output logic [DATA_WIDTH-1:0]       unit_a,
    output logic [DATA_WIDTH-1:0]       unit_b,
    input  logic                        mul_done,
    input  logic                        div_done,
    input  logic [DATA_WIDTH-1:0]       mul_result,
    input  logic [DATA_WIDTH-1:0]       div_quot,
    input  logic [DATA_WIDTH-1:0]       div_rem,
    output logic [IDX_W-1:0]            owner,
    output logic                        busy
);

    arb_state_t            r_state_q,  w_state_d;
    muldiv_op_t            r_op_q,     w_op_d;
    logic [DATA_WIDTH-1:0] r_a_q,      w_a_d;
    logic [DATA_WIDTH-1:0] r_b_q,      w_b_d;
    logic [DATA_WIDTH-1:0] r_result_q, w_result_d;
    logic                  r_dbz_q,    w_dbz_d;
    logic [IDX_W-1:0]      r_owner_q,  w_owner_d;
    logic [IDX_W-1:0]      r_ptr_q,    w_ptr_d;

    logic [IDX_W-1:0]      w_grant_idx;
    logic                  w_grant_any;
    logic                  w_is_div;
    logic [CORES-1:0]      w_req_ready;
    logic [CORES-1:0]      w_rsp_valid;
    logic                  w_mul_start;
    logic                  w_div_start;

    cpu7_rr_picker #(
        .CORES (CORES)
    ) u_picker (
        .req       (req_valid),
        .ptr       (r_ptr_q),
        .grant_idx (w_grant_idx),
        .grant_any (w_grant_any)
    );

    // The reserved opcode falls through to the multiplier.
    assign w_is_div = (r_op_q == OP_DIV) || (r_op_q == OP_REM);

    always_comb begin
        w_state_d   = r_state_q;
        w_op_d      = r_op_q;
        w_a_d       = r_a_q;
        w_b_d       = r_b_q;
        w_result_d  = r_result_q;
        w_dbz_d     = r_dbz_q;
        w_owner_d   = r_owner_q;
        w_ptr_d     = r_ptr_q;
        w_req_ready = '0;
        w_rsp_valid = '0;
        w_mul_start = 1'b0;
        w_div_start = 1'b0;
        case (r_state_q)
            IDLE: begin
                if (w_grant_any) begin
                    w_req_ready[w_grant_idx] = 1'b1;
                    w_op_d    = muldiv_op_t'(req_op[int'(w_grant_idx)*2 +: 2]);
                    w_a_d     = req_a[int'(w_grant_idx)*DATA_WIDTH +: DATA_WIDTH];
                    w_b_d     = req_b[int'(w_grant_idx)*DATA_WIDTH +: DATA_WIDTH];
                    w_owner_d = w_grant_idx;
                    w_dbz_d   = 1'b0;
                    if (int'(w_grant_idx) == CORES - 1) w_ptr_d = '0;
                    else                                w_ptr_d = w_grant_idx + 1'b1;
                    w_state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (w_is_div && (r_b_q == '0)) begin
                    // Resolved here so the divider stays free.
                    w_result_d = (r_op_q == OP_DIV) ? C_DBZ_QUOT[DATA_WIDTH-1:0] : r_a_q;
                    w_dbz_d    = 1'b1;
                    w_state_d  = RESPOND;
                end else begin
                    w_div_start = w_is_div;
                    w_mul_start = !w_is_div;
                    w_state_d   = WAIT;
                end
            end
            WAIT: begin
                if (w_is_div && div_done) begin
                    w_result_d = (r_op_q == OP_DIV) ? div_quot : div_rem;
                    w_state_d  = RESPOND;
                end else if (!w_is_div && mul_done) begin
                    w_result_d = mul_result;
                    w_state_d  = RESPOND;
                end
            end
            RESPOND: begin
                w_rsp_valid[r_owner_q] = 1'b1;
                w_state_d = IDLE;
            end
            default: w_state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q  <= IDLE;
            r_op_q     <= OP_MUL;
            r_a_q      <= '0;
            r_b_q      <= '0;
            r_result_q <= '0;
            r_dbz_q    <= 1'b0;
            r_owner_q  <= '0;
            r_ptr_q    <= '0;
        end else begin
            r_state_q  <= w_state_d;
            r_op_q     <= w_op_d;
            r_a_q      <= w_a_d;
            r_b_q      <= w_b_d;
            r_result_q <= w_result_d;
            r_dbz_q    <= w_dbz_d;
            r_owner_q  <= w_owner_d;
            r_ptr_q    <= w_ptr_d;
        end
    end

    // Strobes are masked while rst is asserted so every output reads 0.
    assign req_ready = rst ? '0 : w_req_ready;
    assign rsp_valid = rst ? '0 : w_rsp_valid;
    assign mul_start = !rst && w_mul_start;
    assign div_start = !rst && w_div_start;
    assign rsp_dbz   = !rst && (r_state_q == RESPOND) && r_dbz_q;
    assign rsp_data  = r_result_q;
    assign unit_a    = r_a_q;
    assign unit_b    = r_b_q;
    assign owner     = r_owner_q;
    assign busy      = (r_state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_cpu7_muldiv_arbiter.sv
// ============================================================================
// tb_cpu7_muldiv_arbiter : directed vectors against hand-computed results
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_cpu7_muldiv_arbiter;

    localparam int CORES = 2;
    localparam int DW    = 28;

    logic              clk = 1'b0;
    logic              rst;
    logic [CORES-1:0]  req_valid;
    logic [CORES*2-1:0] req_op;
    logic [CORES*DW-1:0] req_a;
    logic [CORES*DW-1:0] req_b;
    logic [CORES-1:0]  req_ready;
    logic [CORES-1:0]  rsp_valid;
    logic [DW-1:0]     rsp_data;
    logic              rsp_dbz;
    logic              mul_start;
    logic              div_start;
    logic [DW-1:0]     unit_a;
    logic [DW-1:0]     unit_b;
    logic              mul_done;
    logic              div_done;
    logic [DW-1:0]     mul_result;
    logic [DW-1:0]     div_quot;
    logic [DW-1:0]     div_rem;
    logic              owner;
    logic              busy;

    cpu7_muldiv_arbiter #(
        .CORES      (CORES),
        .DATA_WIDTH (DW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rsp_dbz    (rsp_dbz),
        .mul_start  (mul_start),
        .div_start  (div_start),
        .unit_a     (unit_a),
        .unit_b     (unit_b),
        .mul_done   (mul_done),
        .div_done   (div_done),
        .mul_result (mul_result),
        .div_quot   (div_quot),
        .div_rem    (div_rem),
        .owner      (owner),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Unit models: multiplier start-to-done 3 cycles, divider 4 cycles.
    int      mcnt, dcnt;
    logic    m_done_mdl, d_done_mdl;
    logic    inj_mul, inj_div;
    int      n_mst, n_dst, n_rdy1;

    assign mul_done = m_done_mdl | inj_mul;
    assign div_done = d_done_mdl | inj_div;

    always @(posedge clk) begin
        if (rst) begin
            mcnt <= 0; dcnt <= 0; m_done_mdl <= 1'b0; d_done_mdl <= 1'b0;
            mul_result <= '0; div_quot <= '0; div_rem <= '0;
        end else begin
            m_done_mdl <= (mcnt == 1);
            d_done_mdl <= (dcnt == 1);
            if (mcnt != 0) mcnt <= mcnt - 1;
            if (dcnt != 0) dcnt <= dcnt - 1;
            if (mul_start) begin
                mcnt       <= 2;
                mul_result <= DW'(unit_a * unit_b);
            end
            if (div_start) begin
                dcnt     <= 3;
                div_quot <= (unit_b != 0) ? unit_a / unit_b : '1;
                div_rem  <= (unit_b != 0) ? unit_a % unit_b : unit_a;
            end
        end
    end

    always @(posedge clk) begin
        if (mul_start)    n_mst  <= n_mst + 1;
        if (div_start)    n_dst  <= n_dst + 1;
        if (req_ready[1]) n_rdy1 <= n_rdy1 + 1;
    end

    int n_vec = 0;
    int n_miscmp = 0;
    int cyc = 0;
    int g_cyc = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic set_req(input int core, input logic [1:0] op, input logic [DW-1:0] a,
                           input logic [DW-1:0] b);
        req_op[core*2 +: 2]  = op;
        req_a[core*DW +: DW] = a;
        req_b[core*DW +: DW] = b;
    endtask

    // Requests from one core in an IDLE cycle; returns in the ISSUE cycle.
    task automatic issue(input string tag, input int core, input logic [1:0] op,
                         input logic [DW-1:0] a, input logic [DW-1:0] b);
        set_req(core, op, a, b);
        req_valid[core] = 1'b1;
        #1;
        check({tag, "_ready"}, 64'(req_ready), 64'(1 << core));
        g_cyc = cyc;
        step();
        req_valid[core] = 1'b0;
        #1;
    endtask

    task automatic wait_rsp(input string tag);
        int n;
        n = 0;
        while (rsp_valid == '0 && n < 40) begin
            step();
            n++;
        end
        if (rsp_valid == '0) check({tag, "_timeout"}, 64'd0, 64'd1);
    endtask

    int base_mst, base_dst, base_rdy1;
    logic [CORES-1:0] exp_g;

    initial begin
        rst = 1'b1; req_valid = '0; req_op = '0; req_a = '0; req_b = '0;
        inj_mul = 1'b0; inj_div = 1'b0;
        n_mst = 0; n_dst = 0; n_rdy1 = 0;
        step(); step();
        check("rst_busy",      64'(busy),      64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_mul_start", 64'(mul_start), 64'd0);
        check("rst_unit_a",    64'(unit_a),    64'd0);
        check("rst_owner",     64'(owner),     64'd0);
        check("rst_rsp_data",  64'(rsp_data),  64'd0);
        rst = 1'b0;
        step();

        // Single MUL 7*6 on core0
        base_mst = n_mst;
        issue("mul", 0, 2'd0, 28'd7, 28'd6);
        check("mul_start",   64'(mul_start), 64'd1);
        check("mul_div_st",  64'(div_start), 64'd0);
        check("mul_unit_a",  64'(unit_a),    64'd7);
        check("mul_unit_b",  64'(unit_b),    64'd6);
        check("mul_busy",    64'(busy),      64'd1);
        wait_rsp("mul");
        check("mul_lat",     64'(cyc - g_cyc), 64'd5);
        check("mul_rsp_v",   64'(rsp_valid),   64'b01);
        check("mul_data",    64'(rsp_data),    64'd42);
        check("mul_dbz",     64'(rsp_dbz),     64'd0);
        check("mul_nstart",  64'(n_mst - base_mst), 64'd1);
        step();
        check("mul_idle",    64'(busy),      64'd0);
        check("mul_rsp_clr", 64'(rsp_valid), 64'd0);

        // Divide-by-zero on core1, DIV then REM
        base_dst = n_dst;
        issue("dbz_div", 1, 2'd1, 28'd100, 28'd0);
        check("dbz_div_start", 64'(div_start), 64'd0);
        wait_rsp("dbz_div");
        check("dbz_div_lat",  64'(cyc - g_cyc), 64'd2);
        check("dbz_div_v",    64'(rsp_valid),   64'b10);
        check("dbz_div_data", 64'(rsp_data),    64'hFFFFFFF);
        check("dbz_div_flag", 64'(rsp_dbz),     64'd1);
        step();
        issue("dbz_rem", 1, 2'd2, 28'd100, 28'd0);
        wait_rsp("dbz_rem");
        check("dbz_rem_lat",  64'(cyc - g_cyc), 64'd2);
        check("dbz_rem_data", 64'(rsp_data),    64'd100);
        check("dbz_rem_flag", 64'(rsp_dbz),     64'd1);
        check("dbz_nstart",   64'(n_dst - base_dst), 64'd0);
        step();

        // Round robin: both cores hold requests; ptr is 0 after last grant to core1
        set_req(0, 2'd0, 28'd3, 28'd5);
        set_req(1, 2'd1, 28'd20, 28'd6);
        req_valid = 2'b11;
        for (int g = 0; g < 4; g++) begin
            int n;
            logic [DW-1:0] exp_d;
            exp_g = (g % 2 == 0) ? 2'b01 : 2'b10;
            exp_d = (g % 2 == 0) ? 28'd15 : ((g == 1) ? 28'd3 : 28'd2);
            if (g == 3) set_req(1, 2'd2, 28'd20, 28'd6);
            #1;
            n = 0;
            while (req_ready == '0 && n < 40) begin
                step();
                n++;
            end
            check($sformatf("rr_grant%0d", g), 64'(req_ready), 64'(exp_g));
            step();
            wait_rsp("rr");
            check($sformatf("rr_rsp%0d", g),  64'(rsp_valid), 64'(exp_g));
            check($sformatf("rr_data%0d", g), 64'(rsp_data),  64'(exp_d));
            step();
        end
        req_valid = '0;
        step();

        // Foreign div_done during a MUL WAIT
        issue("fd", 0, 2'd0, 28'd9, 28'd9);
        step();
        inj_div = 1'b1;
        step();
        inj_div = 1'b0;
        #1;
        check("fd_no_rsp", 64'(rsp_valid), 64'd0);
        check("fd_busy",   64'(busy),      64'd1);
        wait_rsp("fd");
        check("fd_lat",  64'(cyc - g_cyc), 64'd5);
        check("fd_data", 64'(rsp_data),    64'd81);
        step();

        // Reset mid-WAIT; ptr is 1 here, so a post-reset grant to core0 shows ptr cleared
        issue("rw", 0, 2'd0, 28'd2, 28'd3);
        step();
        check("rw_in_wait", 64'(busy), 64'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check("rw_busy",  64'(busy),      64'd0);
        check("rw_rsp_v", 64'(rsp_valid), 64'd0);
        inj_mul = 1'b1;
        step();
        inj_mul = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("rw_stale%0d", k), 64'({busy, rsp_valid}), 64'd0);
            step();
        end
        set_req(0, 2'd0, 28'd4, 28'd4);
        set_req(1, 2'd0, 28'd5, 28'd5);
        req_valid = 2'b11;
        #1;
        check("rw_ptr0", 64'(req_ready), 64'b01);
        step();
        req_valid = '0;
        wait_rsp("rw");
        check("rw_data", 64'(rsp_data), 64'd16);
        step();

        // Withdrawn request from core1 while core0 is served
        base_rdy1 = n_rdy1;
        issue("wd", 0, 2'd0, 28'd11, 28'd2);
        step();
        req_valid[1] = 1'b1;
        set_req(1, 2'd0, 28'd1, 28'd1);
        step();
        req_valid[1] = 1'b0;
        wait_rsp("wd");
        check("wd_rsp_v", 64'(rsp_valid), 64'b01);
        check("wd_data",  64'(rsp_data),  64'd22);
        for (int k = 0; k < 4; k++) step();
        check("wd_idle",  64'(busy),             64'd0);
        check("wd_rdy1",  64'(n_rdy1 - base_rdy1), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
